// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a valid/ready handshake and a two-entry
// skid buffer. up_ready depends only on registered state and the global
// enables, so it does not combinationally follow dn_ready. An empty stage
// presents NOP_VAL downstream. A saturating counter records bubble cycles.
module pipe_stage_skid #(
    parameter int                 DATA_W  = 64,
    parameter logic [DATA_W-1:0]  NOP_VAL = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              stall,
    input  logic              clear,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // The state encoding is {main_v, skid_v}. ILLEGAL (0,1) must never be
    // reached: the skid entry is only filled while the main entry is occupied.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        ILLEGAL = 2'b01,
        ONE     = 2'b10,
        FULL    = 2'b11
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   main_d_reg, main_d_next;
    logic [DATA_W-1:0]   skid_d_reg, skid_d_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic en;
    logic main_v;
    logic skid_v;
    logic up_fire;
    logic dn_fire;

    assign en       = rdy_in & ~stall;
    assign main_v   = state_reg[1];
    assign skid_v   = state_reg[0];
    assign up_ready = en & ~clear & ~skid_v;
    assign up_fire  = up_valid & up_ready;
    assign dn_fire  = main_v & dn_ready & en;

    assign dn_valid   = main_v;
    assign dn_data    = main_d_reg;
    assign bubble_cnt = cnt_reg;

    // Next-state logic. Clear has priority over the enable; when the enable
    // is low, everything holds.
    always_comb begin
        state_next  = state_reg;
        main_d_next = main_d_reg;
        skid_d_next = skid_d_reg;
        cnt_next    = cnt_reg;

        if (clear) begin
            state_next  = EMPTY;
            main_d_next = NOP_VAL;
            skid_d_next = NOP_VAL;
        end else if (en) begin
            case (state_reg)
                EMPTY: begin
                    if (up_fire) begin
                        state_next  = ONE;
                        main_d_next = up_data;
                    end
                end
                ONE: begin
                    if (dn_fire && up_fire) begin
                        main_d_next = up_data;
                    end else if (dn_fire) begin
                        state_next  = EMPTY;
                        main_d_next = NOP_VAL;
                    end else if (up_fire) begin
                        state_next  = FULL;
                        skid_d_next = up_data;
                    end
                end
                FULL: begin
                    if (dn_fire) begin
                        state_next  = ONE;
                        main_d_next = skid_d_reg;
                        skid_d_next = NOP_VAL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_next  = EMPTY;
                    main_d_next = NOP_VAL;
                    skid_d_next = NOP_VAL;
                end
            endcase
        end

        // A bubble is an enabled, non-clearing cycle in which nothing is
        // presented downstream. The counter sticks at all-ones.
        if (en && !main_v && !clear && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // State and storage registers. Reset discards any in-flight beats at once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg  <= EMPTY;
            main_d_reg <= NOP_VAL;
            skid_d_reg <= NOP_VAL;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            main_d_reg <= main_d_next;
            skid_d_reg <= skid_d_next;
            cnt_reg    <= cnt_next;
        end
    end

    // The skid entry is never valid without the main entry.
    a_no_illegal_state: assert property (@(posedge clk_in) disable iff (rst_in)
        state_reg != ILLEGAL);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid. A table of per-cycle stimulus rows carries the
// expected handshake outputs and bubble count. A scoreboard queue tracks
// accepted beats, and the downstream payload is compared against its head.
module tb_pipe_stage_skid;

    localparam int                DATA_W  = 64;
    localparam int                CNT_W   = 4;
    localparam logic [DATA_W-1:0] NOP     = 64'hDEAD_BEEF_CAFE_F00D;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              stall;
    logic              clear;
    logic              up_valid;
    logic              up_ready;
    logic [DATA_W-1:0] up_data;
    logic              dn_valid;
    logic              dn_ready;
    logic [DATA_W-1:0] dn_data;
    logic [CNT_W-1:0]  bubble_cnt;

    pipe_stage_skid #(
        .DATA_W  (DATA_W),
        .NOP_VAL (NOP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .stall      (stall),
        .clear      (clear),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .dn_valid   (dn_valid),
        .dn_ready   (dn_ready),
        .dn_data    (dn_data),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          rst;   // pulse async reset before this row
        bit          rdy;
        bit          stl;
        bit          clr;
        bit          uv;
        logic [63:0] ud;
        bit          dr;
        bit          eur;   // expected up_ready
        bit          edv;   // expected dn_valid
        int          ecnt;  // expected bubble_cnt
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    function automatic void add(input bit rst, input bit rdy, input bit stl, input bit clr,
                                input bit uv, input logic [63:0] ud, input bit dr,
                                input bit eur, input bit edv, input int ecnt);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.stl = stl; v.clr = clr;
        v.uv = uv; v.ud = ud; v.dr = dr;
        v.eur = eur; v.edv = edv; v.ecnt = ecnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Asynchronous reset pulse in the middle of a low clock phase; outputs
    // must settle without any clock edge.
    task automatic do_reset(input int row);
        @(negedge clk_in);
        rdy_in = 1'b0; stall = 1'b0; clear = 1'b0;
        up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        chk("reset_dn_valid", row, 64'(dn_valid), 64'(0));
        chk("reset_dn_data", row, dn_data, NOP);
        chk("reset_up_ready", row, 64'(up_ready), 64'(0));
        chk("reset_bubble_cnt", row, 64'(bubble_cnt), 64'(0));
        $display("row %0d: async reset, dn_valid=%0b dn_data=%h", row, dn_valid, dn_data);
        @(negedge clk_in);
        rst_in = 1'b0;
        sb.delete();
    endtask

    task automatic apply(input int row, input vec_t v);
        if (v.rst) do_reset(row);
        @(negedge clk_in);
        rdy_in = v.rdy; stall = v.stl; clear = v.clr;
        up_valid = v.uv; up_data = v.ud; dn_ready = v.dr;
        #1;
        chk("up_ready", row, 64'(up_ready), 64'(v.eur));
        chk("dn_valid", row, 64'(dn_valid), 64'(v.edv));
        chk("bubble_cnt", row, 64'(bubble_cnt), 64'(v.ecnt));
        if (!dn_valid) begin
            chk("dn_data_nop", row, dn_data, NOP);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dn_data_extra row %0d: got %h expected no beat", row, dn_data);
        end else begin
            chk("dn_data_order", row, dn_data, sb[0]);
        end
        $display("row %0d: up_v=%0b up_d=%h up_r=%0b dn_v=%0b dn_d=%h cnt=%0d",
                 row, up_valid, up_data, up_ready, dn_valid, dn_data, bubble_cnt);
        if (dn_valid && dn_ready && rdy_in && !stall && sb.size() > 0) void'(sb.pop_front());
        if (up_valid && up_ready) sb.push_back(up_data);
        if (clear) sb.delete();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; stall = 1'b0; clear = 1'b0;
        up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;

        // Bubble counter: idle while not ready, count, freeze on stall, saturate at 15.
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)  add(0, 1, 0, 0, 0, 0, 1, 1, 0, i);
        for (int i = 0; i < 3; i++)  add(0, 1, 1, 0, 0, 0, 1, 0, 0, 5);
        for (int i = 0; i < 17; i++) add(0, 1, 0, 0, 0, 0, 1, 1, 0, (5 + i > 15) ? 15 : 5 + i);

        // Streaming 1..8 with dn_ready high: one-cycle latency, no gaps.
        add(1, 1, 0, 0, 1, 1, 1, 1, 0, 0);
        for (int d = 2; d <= 8; d++) add(0, 1, 0, 0, 1, 64'(d), 1, 1, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 2);

        // Backpressure: two beats fill main and skid, up_ready drops, drain in order.
        add(1, 1, 0, 0, 1, 1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 2, 0, 1, 1, 1);
        add(0, 1, 0, 0, 1, 3, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 3, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 3, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1, 3, 1, 1, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 1);

        // Stall / rdy_in low with a full stage: everything frozen.
        add(1, 1, 0, 0, 1, 64'hA1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 64'hA2, 0, 1, 1, 1);
        add(0, 1, 1, 0, 1, 64'hA3, 1, 0, 1, 1);
        add(0, 0, 0, 0, 1, 64'hA3, 1, 0, 1, 1);
        add(0, 1, 1, 0, 1, 64'hA3, 1, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 2);

        // Clear on a full stage with a concurrent beat 0x55 that must be dropped.
        add(1, 1, 0, 0, 1, 64'h11, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 64'h22, 0, 1, 1, 1);
        add(0, 1, 0, 1, 1, 64'h55, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 1, 0, 0, 1, 64'h66, 1, 1, 0, 2);
        add(0, 1, 0, 0, 0, 0, 1, 1, 1, 3);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 3);
        add(0, 1, 0, 0, 1, 64'h77, 0, 1, 0, 4);
        add(0, 1, 0, 0, 1, 64'h88, 0, 1, 1, 5);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Reset while the stage is full: both in-flight beats discarded.
        do_reset(vecs.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
